// File: rtl/tx_resp_arbiter.sv
// Round-robin arbiter sharing the UART TX parallel port between ALU results (sent as two
// bytes, low first) and RegFile read data, each source with a one-entry holding buffer.
module tx_resp_arbiter #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned OUT_WIDTH = 16  // must equal 2*WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [OUT_WIDTH-1:0] ALU_OUT,
   input  logic                 ALU_OUT_VALID,
   input  logic [WIDTH-1:0]     Rd_DATA,
   input  logic                 Rd_DATA_Valid,
   input  logic                 Busy,
   output logic [WIDTH-1:0]     TX_P_DATA,
   output logic                 TX_D_VLD,
   output logic                 ALU_PEND,
   output logic                 RD_PEND,
   output logic                 ALU_DROP,
   output logic                 RD_DROP
);

   typedef enum logic [2:0] {
      StIdle,
      StSendLo,
      StWaitLo,
      StSendHi,
      StWaitHi,
      StSendRd,
      StWaitRd
   } state_e;

   state_e                 r_state_q;
   state_e                 w_state_d;
   logic [OUT_WIDTH-1:0]   r_tx_buf_q;
   logic [OUT_WIDTH-1:0]   w_tx_buf_d;
   logic [WIDTH-1:0]       r_tx_data_q;
   logic [WIDTH-1:0]       w_tx_data_d;
   logic                   r_tx_vld_q;
   logic                   w_tx_vld_d;
   logic [OUT_WIDTH-1:0]   r_alu_hold_q;
   logic [OUT_WIDTH-1:0]   w_alu_hold_d;
   logic [WIDTH-1:0]       r_rd_hold_q;
   logic [WIDTH-1:0]       w_rd_hold_d;
   logic                   r_alu_pend_q;
   logic                   w_alu_pend_d;
   logic                   r_rd_pend_q;
   logic                   w_rd_pend_d;
   logic                   r_alu_drop_q;
   logic                   w_alu_drop_d;
   logic                   r_rd_drop_q;
   logic                   w_rd_drop_d;
   logic                   r_last_rd_q;
   logic                   w_last_rd_d;
   logic                   w_grant_alu;
   logic                   w_grant_rd;

   // Pointer moves only on contested grants, so an uncontested grant never steals the
   // loser's turn at the next tie.
   always_comb begin
      w_grant_alu = 1'b0;
      w_grant_rd  = 1'b0;
      w_last_rd_d = r_last_rd_q;
      if (r_state_q == StIdle && !Busy) begin
         if (r_alu_pend_q && r_rd_pend_q) begin
            if (r_last_rd_q) begin
               w_grant_alu = 1'b1;
               w_last_rd_d = 1'b0;
            end else begin
               w_grant_rd  = 1'b1;
               w_last_rd_d = 1'b1;
            end
         end else if (r_alu_pend_q) begin
            w_grant_alu = 1'b1;
         end else if (r_rd_pend_q) begin
            w_grant_rd = 1'b1;
         end
      end
   end

   // A pulse landing on the grant cycle refills the buffer the grant is emptying.
   always_comb begin
      w_alu_hold_d = r_alu_hold_q;
      w_alu_pend_d = r_alu_pend_q && !w_grant_alu;
      w_alu_drop_d = 1'b0;
      if (ALU_OUT_VALID) begin
         if (!r_alu_pend_q || w_grant_alu) begin
            w_alu_hold_d = ALU_OUT;
            w_alu_pend_d = 1'b1;
         end else begin
            w_alu_drop_d = 1'b1;
         end
      end

      w_rd_hold_d = r_rd_hold_q;
      w_rd_pend_d = r_rd_pend_q && !w_grant_rd;
      w_rd_drop_d = 1'b0;
      if (Rd_DATA_Valid) begin
         if (!r_rd_pend_q || w_grant_rd) begin
            w_rd_hold_d = Rd_DATA;
            w_rd_pend_d = 1'b1;
         end else begin
            w_rd_drop_d = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_d   = r_state_q;
      w_tx_buf_d  = r_tx_buf_q;
      w_tx_data_d = r_tx_data_q;
      w_tx_vld_d  = r_tx_vld_q;
      case (r_state_q)
         StIdle: begin
            w_tx_vld_d = 1'b0;
            if (w_grant_alu) begin
               w_tx_buf_d  = r_alu_hold_q;
               w_tx_data_d = r_alu_hold_q[WIDTH-1:0];
               w_tx_vld_d  = 1'b1;
               w_state_d   = StSendLo;
            end else if (w_grant_rd) begin
               w_tx_buf_d  = {{(OUT_WIDTH-WIDTH){1'b0}}, r_rd_hold_q};
               w_tx_data_d = r_rd_hold_q;
               w_tx_vld_d  = 1'b1;
               w_state_d   = StSendRd;
            end
         end
         StSendLo: begin
            if (Busy) begin
               w_tx_vld_d = 1'b0;
               w_state_d  = StWaitLo;
            end
         end
         StWaitLo: begin
            if (!Busy) begin
               w_tx_data_d = r_tx_buf_q[OUT_WIDTH-1:WIDTH];
               w_tx_vld_d  = 1'b1;
               w_state_d   = StSendHi;
            end
         end
         StSendHi: begin
            if (Busy) begin
               w_tx_vld_d = 1'b0;
               w_state_d  = StWaitHi;
            end
         end
         StSendRd: begin
            if (Busy) begin
               w_tx_vld_d = 1'b0;
               w_state_d  = StWaitRd;
            end
         end
         StWaitHi, StWaitRd: begin
            if (!Busy) begin
               w_state_d = StIdle;
            end
         end
         default: begin
            w_tx_vld_d = 1'b0;
            w_state_d  = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state_q    <= StIdle;
         r_tx_buf_q   <= '0;
         r_tx_data_q  <= '0;
         r_tx_vld_q   <= 1'b0;
         r_alu_hold_q <= '0;
         r_rd_hold_q  <= '0;
         r_alu_pend_q <= 1'b0;
         r_rd_pend_q  <= 1'b0;
         r_alu_drop_q <= 1'b0;
         r_rd_drop_q  <= 1'b0;
         r_last_rd_q  <= 1'b1;
      end else begin
         r_state_q    <= w_state_d;
         r_tx_buf_q   <= w_tx_buf_d;
         r_tx_data_q  <= w_tx_data_d;
         r_tx_vld_q   <= w_tx_vld_d;
         r_alu_hold_q <= w_alu_hold_d;
         r_rd_hold_q  <= w_rd_hold_d;
         r_alu_pend_q <= w_alu_pend_d;
         r_rd_pend_q  <= w_rd_pend_d;
         r_alu_drop_q <= w_alu_drop_d;
         r_rd_drop_q  <= w_rd_drop_d;
         r_last_rd_q  <= w_last_rd_d;
      end
   end

   assign TX_P_DATA = r_tx_data_q;
   assign TX_D_VLD  = r_tx_vld_q;
   assign ALU_PEND  = r_alu_pend_q;
   assign RD_PEND   = r_rd_pend_q;
   assign ALU_DROP  = r_alu_drop_q;
   assign RD_DROP   = r_rd_drop_q;

endmodule

// File: tb/tb_tx_resp_arbiter.sv
// Scoreboard bench for tx_resp_arbiter: a UART busy model acknowledges each byte and
// every TX_D_VLD rise is checked against the queue of expected bytes.
module tb_tx_resp_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] ALU_OUT;
   logic        ALU_OUT_VALID;
   logic [7:0]  Rd_DATA;
   logic        Rd_DATA_Valid;
   logic        Busy;
   logic [7:0]  TX_P_DATA;
   logic        TX_D_VLD;
   logic        ALU_PEND;
   logic        RD_PEND;
   logic        ALU_DROP;
   logic        RD_DROP;

   logic [7:0] exp_q[$];
   int         n_vec     = 0;
   int         n_err     = 0;
   int         vld_rises = 0;
   int         bphase    = 0;
   int         bcnt      = 0;
   bit         busy_force = 1'b0;
   bit         mon_prev   = 1'b0;
   bit         tb_last_rd = 1'b1;

   always #5 clk = ~clk;

   tx_resp_arbiter #(
      .WIDTH     (8),
      .OUT_WIDTH (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ALU_OUT       (ALU_OUT),
      .ALU_OUT_VALID (ALU_OUT_VALID),
      .Rd_DATA       (Rd_DATA),
      .Rd_DATA_Valid (Rd_DATA_Valid),
      .Busy          (Busy),
      .TX_P_DATA     (TX_P_DATA),
      .TX_D_VLD      (TX_D_VLD),
      .ALU_PEND      (ALU_PEND),
      .RD_PEND       (RD_PEND),
      .ALU_DROP      (ALU_DROP),
      .RD_DROP       (RD_DROP)
   );

   task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // UART model: Busy rises 2 cycles after a byte is offered, stays high 3 cycles.
   initial begin
      Busy = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_force) begin
            Busy   = 1'b1;
            bphase = 0;
         end else begin
            case (bphase)
               0: begin
                  Busy = 1'b0;
                  if (TX_D_VLD) begin
                     bcnt   = 1;
                     bphase = 1;
                  end
               end
               1: begin
                  if (bcnt == 0) begin
                     Busy   = 1'b1;
                     bcnt   = 2;
                     bphase = 2;
                  end else begin
                     bcnt--;
                  end
               end
               default: begin
                  if (bcnt == 0) begin
                     Busy   = 1'b0;
                     bphase = 0;
                  end else begin
                     bcnt--;
                  end
               end
            endcase
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (TX_D_VLD && !mon_prev) begin
            vld_rises++;
            check_eq("byte_expected", 16'(exp_q.size() > 0), 16'd1);
            if (exp_q.size() > 0) begin
               check_eq("tx_byte", {8'h00, TX_P_DATA}, {8'h00, exp_q.pop_front()});
            end
         end
         mon_prev = TX_D_VLD;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   // Contested grants alternate; an uncontested grant leaves the pointer alone.
   task automatic push_tie(input logic [15:0] a, input logic [7:0] r);
      if (tb_last_rd) begin
         exp_q.push_back(a[7:0]);
         exp_q.push_back(a[15:8]);
         exp_q.push_back(r);
         tb_last_rd = 1'b0;
      end else begin
         exp_q.push_back(r);
         exp_q.push_back(a[7:0]);
         exp_q.push_back(a[15:8]);
         tb_last_rd = 1'b1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      tb_last_rd = 1'b1;
   endtask

   task automatic pulse_alu(input logic [15:0] d);
      ALU_OUT = d;
      ALU_OUT_VALID = 1'b1;
      @(negedge clk);
      ALU_OUT_VALID = 1'b0;
   endtask

   task automatic pulse_rd(input logic [7:0] d);
      Rd_DATA = d;
      Rd_DATA_Valid = 1'b1;
      @(negedge clk);
      Rd_DATA_Valid = 1'b0;
   endtask

   task automatic pulse_both(input logic [15:0] a, input logic [7:0] r);
      ALU_OUT = a;
      Rd_DATA = r;
      ALU_OUT_VALID = 1'b1;
      Rd_DATA_Valid = 1'b1;
      @(negedge clk);
      ALU_OUT_VALID = 1'b0;
      Rd_DATA_Valid = 1'b0;
   endtask

   task automatic wait_vld(input bit level, input int budget, input string tag);
      int n = 0;
      while (TX_D_VLD !== level && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, {15'd0, TX_D_VLD}, {15'd0, level});
   endtask

   task automatic drain(input string tag);
      int n = 0;
      while ((exp_q.size() != 0 || Busy || bphase != 0 || TX_D_VLD) && n < 300) begin
         @(negedge clk);
         n++;
      end
      check_eq(tag, 16'(exp_q.size()), 16'd0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int rises0;
      rst = 1'b1;
      ALU_OUT = '0;
      ALU_OUT_VALID = 1'b0;
      Rd_DATA = '0;
      Rd_DATA_Valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      check_eq("rst_data", {8'h00, TX_P_DATA}, 16'h0000);
      check_eq("rst_vld", {15'd0, TX_D_VLD}, 16'd0);
      check_eq("rst_alu_pend", {15'd0, ALU_PEND}, 16'd0);
      check_eq("rst_rd_pend", {15'd0, RD_PEND}, 16'd0);
      check_eq("rst_alu_drop", {15'd0, ALU_DROP}, 16'd0);
      check_eq("rst_rd_drop", {15'd0, RD_DROP}, 16'd0);

      // Single RD byte: PEND in N+1 only, valid in N+2, held until Busy is sampled.
      exp_q.push_back(8'h3C);
      pulse_rd(8'h3C);
      check_eq("rd_pend_n1", {15'd0, RD_PEND}, 16'd1);
      check_eq("vld_n1", {15'd0, TX_D_VLD}, 16'd0);
      @(negedge clk);
      check_eq("rd_pend_n2", {15'd0, RD_PEND}, 16'd0);
      check_eq("vld_n2", {15'd0, TX_D_VLD}, 16'd1);
      check_eq("data_n2", {8'h00, TX_P_DATA}, 16'h003C);
      repeat (2) @(negedge clk);
      check_eq("vld_held", {15'd0, TX_D_VLD}, 16'd1);
      @(negedge clk);
      check_eq("vld_drop", {15'd0, TX_D_VLD}, 16'd0);
      drain("rd_single");

      rises0 = vld_rises;
      exp_q.push_back(8'h5A);
      exp_q.push_back(8'hA5);
      pulse_alu(16'hA55A);
      drain("alu_single");
      check_eq("alu_two_vld", 16'(vld_rises - rises0), 16'd2);

      do_reset();
      push_tie(16'h1234, 8'h77);
      pulse_both(16'h1234, 8'h77);
      drain("tie_alu_first");
      push_tie(16'hBEEF, 8'h11);
      pulse_both(16'hBEEF, 8'h11);
      drain("tie_rd_first");

      // Busy stuck high: second RD pulse is dropped, first survives.
      busy_force = 1'b1;
      repeat (2) @(negedge clk);
      rises0 = vld_rises;
      Rd_DATA = 8'h01;
      Rd_DATA_Valid = 1'b1;
      @(negedge clk);
      check_eq("drop_none", {15'd0, RD_DROP}, 16'd0);
      Rd_DATA = 8'h02;
      @(negedge clk);
      Rd_DATA_Valid = 1'b0;
      check_eq("drop_pulse", {15'd0, RD_DROP}, 16'd1);
      check_eq("drop_pend", {15'd0, RD_PEND}, 16'd1);
      @(negedge clk);
      check_eq("drop_once", {15'd0, RD_DROP}, 16'd0);
      repeat (10) @(negedge clk);
      check_eq("stuck_no_vld", 16'(vld_rises - rises0), 16'd0);
      exp_q.push_back(8'h01);
      busy_force = 1'b0;
      drain("stuck_release");

      // Reset in WAIT_LO with RD pending: high byte and RD byte must never appear.
      do_reset();
      exp_q.push_back(8'hFE);
      pulse_alu(16'hCAFE);
      wait_vld(1'b1, 10, "cafe_lo_vld");
      pulse_rd(8'h55);
      wait_vld(1'b0, 10, "cafe_wait_lo");
      check_eq("mid_rd_pend", {15'd0, RD_PEND}, 16'd1);
      rst = 1'b1;
      @(negedge clk);
      check_eq("mid_rst_data", {8'h00, TX_P_DATA}, 16'h0000);
      check_eq("mid_rst_vld", {15'd0, TX_D_VLD}, 16'd0);
      check_eq("mid_rst_alu_pend", {15'd0, ALU_PEND}, 16'd0);
      check_eq("mid_rst_rd_pend", {15'd0, RD_PEND}, 16'd0);
      rst = 1'b0;
      tb_last_rd = 1'b1;
      rises0 = vld_rises;
      repeat (20) @(negedge clk);
      check_eq("mid_rst_silent", 16'(vld_rises - rises0), 16'd0);
      exp_q.push_back(8'h99);
      pulse_rd(8'h99);
      drain("post_rst_clean");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
